// File: rtl/exp_series_eval_if.sv
// Handshake/LUT bundle for the e^x series evaluator.
//   start    : request an evaluation (sampled only while the evaluator is idle)
//   x        : operand, unsigned Q0.COEF_W, latched when start is accepted
//   lut_addr : coefficient LUT address driven by the evaluator (addr n-1 holds 1/n!)
//   lut_data : coefficient returned combinationally by the external LUT
//   busy     : evaluation in progress
//   done     : one-cycle pulse, result valid in that cycle
//   result   : e^x, unsigned Q2.COEF_W, held until the next done
// The evaluator connects through the slave modport; the operand source / LUT side
// connects through the master modport.
interface exp_series_eval_if #(
    parameter int COEF_W = 16,
    parameter int ADDR_W = 3
);
    logic                start;
    logic [COEF_W-1:0]   x;
    logic [ADDR_W-1:0]   lut_addr;
    logic [COEF_W-1:0]   lut_data;
    logic                busy;
    logic                done;
    logic [COEF_W+1:0]   result;

    modport slave (
        input  start, x, lut_data,
        output lut_addr, busy, done, result
    );

    modport master (
        output start, x, lut_data,
        input  lut_addr, busy, done, result
    );
endinterface

// File: rtl/exp_series_eval.sv
// Sequential Maclaurin evaluator for e^x using Horner's rule:
//   e^x = 1 + x*(c1 + x*(c2 + ... + x*c8)),  cn = 1/n! read from an external LUT.
// One multiply-accumulate per clock: IDLE -> LOAD -> ITER x7 -> FINAL -> IDLE,
// giving a result 10 cycles after start is accepted.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; aborts any run without a done pulse
//   bus  : exp_series_eval_if.slave (start/x in, lut_addr out, lut_data in,
//          busy/done/result out)
module exp_series_eval #(
    parameter int COEF_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int N_TERMS = 8
) (
    input  logic               clk,
    input  logic               rst,
    exp_series_eval_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ITER  = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    localparam logic [COEF_W+1:0] ONE_Q    = {2'b01, {COEF_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(N_TERMS - 1);
    localparam logic [ADDR_W-1:0] ADDR_NXT = ADDR_W'(N_TERMS - 2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [COEF_W-1:0]   x_q, x_d;
    logic [COEF_W:0]     acc_q, acc_d;       // Q1.COEF_W, always < 2
    logic [COEF_W+1:0]   result_q, result_d;
    logic                done_q, done_d;

    logic [2*COEF_W:0]   prod;
    logic [COEF_W:0]     prod_hi;

    // Full-width product x * acc, then drop the fractional LSBs (truncation).
    assign prod    = {{(COEF_W+1){1'b0}}, x_q} * {{COEF_W{1'b0}}, acc_q};
    assign prod_hi = prod[2*COEF_W:COEF_W];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ITER;
            S_ITER:  if (cnt_q == '0) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values, decoded from the current state only.
    always_comb begin
        cnt_d        = cnt_q;
        x_d          = x_q;
        acc_d        = acc_q;
        result_d     = result_q;
        done_d       = 1'b0;
        bus.lut_addr = '0;
        bus.busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) x_d = bus.x;
            end
            S_LOAD: begin
                bus.lut_addr = ADDR_TOP;
                acc_d        = {1'b0, bus.lut_data};
                cnt_d        = ADDR_NXT;
            end
            S_ITER: begin
                bus.lut_addr = cnt_q;
                // Cannot overflow: acc < 2 and x < 1 keep the sum below 2.
                acc_d        = {1'b0, bus.lut_data} + prod_hi;
                cnt_d        = cnt_q - 1'b1;
            end
            S_FINAL: begin
                result_d = ONE_Q + {1'b0, prod_hi};
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_exp_series_eval.sv
module tb_exp_series_eval;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exp_series_eval_if #(.COEF_W(16), .ADDR_W(3)) bus ();

    exp_series_eval #(.COEF_W(16), .ADDR_W(3), .N_TERMS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External coefficient LUT: lut[n-1] = round(65536/n!), with 1/1! clamped to 0xFFFF.
    logic [15:0] lut [0:7] = '{16'hFFFF, 16'h8000, 16'h2AAB, 16'h0AAB,
                               16'h0222, 16'h005B, 16'h000D, 16'h0002};
    assign bus.lut_data = lut[bus.lut_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued e^x in Q2.16, rounded to nearest.
    function automatic int ref_exp(input logic [15:0] xv);
        real r;
        r = $exp(real'(xv) / 65536.0) * 65536.0;
        return $rtoi(r + 0.5);
    endfunction

    task automatic check_tol(input string tag, input logic [15:0] xv, input logic [17:0] res);
        int r, e;
        logic ok;
        r  = ref_exp(xv);
        e  = int'(res) - r;
        ok = (e >= -8) && (e <= 8) && (res >= 18'h10000) && (res <= 18'h2B7E8);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s x=0x%04h observed=0x%05h expected=0x%05h+-8", tag, xv, res, r);
        end
        $display("txn %s x=0x%04h result=0x%05h ref=0x%05h err=%0d", tag, xv, res, r, e);
    endtask

    // Issue one evaluation starting at the current negedge. Checks lut_addr/busy
    // every cycle. inj_k: cycle at which a spurious start with a different x is
    // pulsed; rst_k: cycle at which reset is asserted (run aborted, lat=-1).
    task automatic run(input logic [15:0] xv, input int inj_k, input int rst_k,
                       output logic [17:0] res, output int lat);
        bus.start = 1'b1;
        bus.x     = xv;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (lat <= 8) check("lut_addr", 32'(bus.lut_addr), 32'(8 - lat));
            check("busy_run", 32'(bus.busy), 32'd1);
            if (lat == inj_k) begin
                bus.start = 1'b1;
                bus.x     = ~xv;
            end
            if (lat == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                bus.start = 1'b0;
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_done", 32'(bus.done), 32'd0);
                check("rst_result", 32'(bus.result), 32'd0);
                check("rst_addr", 32'(bus.lut_addr), 32'd0);
                res = bus.result;
                lat = -1;
                return;
            end
            @(negedge clk);
            if (lat == inj_k) bus.start = 1'b0;
            lat++;
        end
        bus.start = 1'b0;
        res = bus.result;
        check("latency", 32'(lat), 32'd10);
        check("busy_done", 32'(bus.busy), 32'd0);
        check("addr_done", 32'(bus.lut_addr), 32'd0);
    endtask

    // Count done pulses over n idle cycles.
    task automatic quiet(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        logic [17:0] res, res2;
        int lat;
        logic [15:0] xv;

        bus.start = 1'b0;
        bus.x     = 16'h0000;

        // 1. reset for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_result", 32'(bus.result), 32'd0);
        check("idle_addr", 32'(bus.lut_addr), 32'd0);
        $display("txn reset busy=%0b done=%0b result=0x%05h", bus.busy, bus.done, bus.result);

        // 2. x = 0 gives exactly 1.0
        run(16'h0000, -1, -1, res, lat);
        check("x0_exact", 32'(res), 32'h10000);
        $display("txn x=0x0000 result=0x%05h lat=%0d", res, lat);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);

        // 3. x = 0.5 and x = max
        run(16'h8000, -1, -1, res, lat);
        check_tol("half", 16'h8000, res);
        @(negedge clk);
        run(16'hFFFF, -1, -1, res, lat);
        check_tol("max", 16'hFFFF, res);

        // 4. back-to-back: new start in the done cycle
        run(16'h4000, -1, -1, res, lat);
        check_tol("quarter_b2b", 16'h4000, res);
        check("b2b_hold", 32'(bus.result), 32'(res));

        // 5. start while busy with a different x is ignored
        @(negedge clk);
        run(16'h3000, 4, -1, res, lat);
        check_tol("ignored_start", 16'h3000, res);
        quiet("single_done", 14);
        check("result_hold", 32'(bus.result), 32'(res));

        // 6. reset mid-run, then a normal run
        run(16'hC000, -1, 5, res, lat);
        quiet("abort_no_done", 14);
        run(16'hC000, -1, -1, res, lat);
        check_tol("after_abort", 16'hC000, res);

        // Sweep: random operands, alternating gapped and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            xv = 16'($urandom);
            if (i % 3 == 0) @(negedge clk);
            run(xv, -1, -1, res2, lat);
            check_tol("sweep", xv, res2);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end
endmodule
